// File: rtl/scroll_sequencer_pkg.sv
// Shared definitions for the scroll sequencer: FSM state encoding,
// prescaler width and the offset rotation helper.
package scroll_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // Wide enough for TICK_DIV up to 2^26 (max count 2^26-1).
    localparam int unsigned PRESC_W = 26;
    localparam int unsigned CNT_W   = 8;

    // dir=1 rotates up (3->0), dir=0 rotates down (0->3).
    function automatic logic [1:0] rot_next(input logic [1:0] off,
                                            input logic       dir);
        return dir ? off + 2'd1 : off - 2'd1;
    endfunction

endpackage

// File: rtl/scroll_sequencer_key_edge_sync.sv
// key_edge_sync: 2-flop synchronizer plus rising-edge detector for a button.
// Ports: clk, rst (async, active-high), din (raw level), rise (1-cycle event).
module key_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       prev_q, prev_d;
    logic [2:0] fill_q, fill_d;

    // fill_q[2] marks that prev_q holds a genuine post-reset sample, so a
    // button held through reset release never looks like a 0->1 edge.
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
        fill_d = {fill_q[1:0], 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            fill_q <= 3'b000;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            fill_q <= fill_d;
        end
    end

    // Combinational from flops so the FSM acts at edge N+2.
    assign rise = fill_q[2] & s2_q & ~prev_q;

endmodule

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: start/pause/stop FSM stepping a 2-bit display rotation
// index once per prescaler tick, with blinking blank while paused.
// Ports: CLOCK_50, aclr (async, active-high), btn_start, btn_pause, sw_dir
// (async levels); offset[1:0], blank, running, paused, step (all registered).
module scroll_sequencer
    import scroll_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned RUN_STEPS = 0
) (
    input  logic       CLOCK_50,
    input  logic       aclr,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       sw_dir,
    output logic [1:0] offset,
    output logic       blank,
    output logic       running,
    output logic       paused,
    output logic       step
);

    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   RUN_LAST  = CNT_W'(RUN_STEPS);
    localparam logic               AUTO_STOP = (RUN_STEPS != 0);

    logic start_rise;
    logic pause_rise;
    logic dir_s1_q, dir_s1_d;
    logic dir_s2_q, dir_s2_d;

    key_edge_sync u_start (
        .clk  (CLOCK_50),
        .rst  (aclr),
        .din  (btn_start),
        .rise (start_rise)
    );

    key_edge_sync u_pause (
        .clk  (CLOCK_50),
        .rst  (aclr),
        .din  (btn_pause),
        .rise (pause_rise)
    );

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         offset_q, offset_d;
    logic               blank_q, blank_d;
    logic               step_q, step_d;
    logic               running_q, running_d;
    logic               paused_q, paused_d;
    logic               tick;

    assign tick = (presc_q == TICK_LAST);

    always_comb begin
        dir_s1_d = sw_dir;
        dir_s2_d = dir_s1_q;

        state_d  = state_q;
        presc_d  = tick ? '0 : presc_q + 1'b1;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        blank_d  = 1'b0;
        step_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // Auto-stop fires the cycle after the last step lands,
                // so the final step is still seen on offset.
                if (start_rise || (AUTO_STOP && cnt_q == RUN_LAST)) begin
                    state_d  = ST_IDLE;
                    offset_d = 2'd0;
                    cnt_d    = '0;
                end else if (pause_rise) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    offset_d = rot_next(offset_q, dir_s2_q);
                    step_d   = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                blank_d = blank_q;
                if (start_rise) begin
                    state_d  = ST_IDLE;
                    offset_d = 2'd0;
                    cnt_d    = '0;
                    blank_d  = 1'b0;
                end else if (pause_rise) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                    blank_d = 1'b0;
                end else if (tick) begin
                    blank_d = ~blank_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                offset_d = 2'd0;
                cnt_d    = '0;
            end
        endcase

        running_d = (state_d == ST_RUN);
        paused_d  = (state_d == ST_PAUSE);
    end

    always_ff @(posedge CLOCK_50 or posedge aclr) begin
        if (aclr) begin
            dir_s1_q  <= 1'b0;
            dir_s2_q  <= 1'b0;
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            cnt_q     <= '0;
            offset_q  <= 2'd0;
            blank_q   <= 1'b0;
            step_q    <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            dir_s1_q  <= dir_s1_d;
            dir_s2_q  <= dir_s2_d;
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            offset_q  <= offset_d;
            blank_q   <= blank_d;
            step_q    <= step_d;
            running_q <= running_d;
            paused_q  <= paused_d;
        end
    end

    assign offset  = offset_q;
    assign blank   = blank_q;
    assign running = running_q;
    assign paused  = paused_q;
    assign step    = step_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Bench for scroll_sequencer: two instances (continuous and RUN_STEPS=5)
// driven with shared random button/switch/reset stimulus against a model.
module tb_scroll_sequencer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       aclr;
    logic       btn_start;
    logic       btn_pause;
    logic       sw_dir;
    logic [1:0] off_c, off_s;
    logic       blank_c, blank_s;
    logic       run_c, run_s;
    logic       pau_c, pau_s;
    logic       step_c, step_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scroll_sequencer #(.TICK_DIV(TD), .RUN_STEPS(0)) dut_c (
        .CLOCK_50  (clk),
        .aclr      (aclr),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .sw_dir    (sw_dir),
        .offset    (off_c),
        .blank     (blank_c),
        .running   (run_c),
        .paused    (pau_c),
        .step      (step_c)
    );

    scroll_sequencer #(.TICK_DIV(TD), .RUN_STEPS(5)) dut_s (
        .CLOCK_50  (clk),
        .aclr      (aclr),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .sw_dir    (sw_dir),
        .offset    (off_s),
        .blank     (blank_s),
        .running   (run_s),
        .paused    (pau_s),
        .step      (step_s)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Model: st 0=idle 1=run 2=pause.
    typedef struct {
        int st;
        int presc;
        int off;
        bit blank;
        bit step;
        int cnt;
    } mdl_t;

    mdl_t mc, ms;
    bit sh1, sh2, sh3, ph1, ph2, ph3, dh1, dh2;
    int nedge;
    int steps_seen;

    function automatic mdl_t mdl_next(mdl_t m, bit se, bit pe, bit dir,
                                      int rs);
        mdl_t n;
        bit tick;
        n = m;
        tick = (m.presc == TD - 1);
        n.presc = tick ? 0 : m.presc + 1;
        n.step = 1'b0;
        case (m.st)
            0: if (se) begin
                n.st = 1; n.presc = 0; n.cnt = 0;
            end
            1: if (se || (rs != 0 && m.cnt == rs)) begin
                n.st = 0; n.off = 0; n.cnt = 0;
            end else if (pe) begin
                n.st = 2; n.blank = 1'b0;
            end else if (tick) begin
                n.off = (m.off + (dir ? 1 : 3)) % 4;
                n.step = 1'b1;
                n.cnt = (m.cnt + 1) % 256;
            end
            default: if (se) begin
                n.st = 0; n.off = 0; n.cnt = 0; n.blank = 1'b0;
            end else if (pe) begin
                n.st = 1; n.presc = 0; n.blank = 1'b0;
            end else if (tick) begin
                n.blank = !m.blank;
            end
        endcase
        return n;
    endfunction

    function automatic logic [7:0] mexp(mdl_t m);
        return {2'b00, m.st == 1, m.st == 2, m.blank, m.step, 2'(m.off)};
    endfunction

    function automatic void mdl_reset();
        mc = '{default: 0};
        ms = '{default: 0};
        {sh1, sh2, sh3, ph1, ph2, ph3, dh1, dh2} = '0;
        nedge = 0;
    endfunction

    always begin
        bit se, pe;
        @(posedge clk);
        if (!aclr) begin
            // Edge first sampled at edge N acts at edge N+2.
            se = sh2 & ~sh3 & (nedge >= 3);
            pe = ph2 & ~ph3 & (nedge >= 3);
            mc = mdl_next(mc, se, pe, dh2, 0);
            ms = mdl_next(ms, se, pe, dh2, 5);
            sh3 = sh2; sh2 = sh1; sh1 = btn_start;
            ph3 = ph2; ph2 = ph1; ph1 = btn_pause;
            dh2 = dh1; dh1 = sw_dir;
            if (nedge < 10) nedge++;
        end
        #1;
        if (aclr) begin
            chk("rst_c", {2'b00, run_c, pau_c, blank_c, step_c, off_c}, 8'h00);
            chk("rst_s", {2'b00, run_s, pau_s, blank_s, step_s, off_s}, 8'h00);
        end else begin
            chk("cont", {2'b00, run_c, pau_c, blank_c, step_c, off_c}, mexp(mc));
            chk("stop5", {2'b00, run_s, pau_s, blank_s, step_s, off_s}, mexp(ms));
            if (step_s) steps_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit s, input bit p, input int hold);
        @(negedge clk);
        if (s) btn_start = 1'b1;
        if (p) btn_pause = 1'b1;
        idle(hold);
        btn_start = 1'b0;
        btn_pause = 1'b0;
    endtask

    // Asynchronous mid-cycle reset; optionally keep start held through release.
    task automatic pulse_reset(input bit hold_start);
        @(negedge clk);
        #($urandom_range(1, 3));
        aclr = 1'b1;
        mdl_reset();
        #1;
        chk("rst_now_c", {2'b00, run_c, pau_c, blank_c, step_c, off_c}, 8'h00);
        chk("rst_now_s", {2'b00, run_s, pau_s, blank_s, step_s, off_s}, 8'h00);
        if (hold_start) btn_start = 1'b1;
        idle($urandom_range(1, 3));
        aclr = 1'b0;
        if (hold_start) begin
            idle($urandom_range(4, 12));
            btn_start = 1'b0;
        end
    endtask

    initial begin
        steps_seen = 0;
        aclr = 1'b1;
        btn_start = 1'b0;
        btn_pause = 1'b0;
        sw_dir = 1'b1;
        mdl_reset();
        idle(3);
        aclr = 1'b0;
        idle(5);

        // Directed walk: run up, pause, resume, run down, stop.
        press(1, 0, 3);
        idle(30);
        press(0, 1, 2);
        idle(20);
        press(0, 1, 2);
        idle(10);
        sw_dir = 1'b0;
        idle(25);
        sw_dir = 1'b1;
        idle(9);
        press(1, 1, 2);
        idle(10);
        press(1, 0, 2);
        idle(9);
        press(0, 1, 2);
        idle(7);
        pulse_reset(1'b1);
        idle(10);

        for (int i = 0; i < 500; i++) begin
            int a;
            a = $urandom_range(0, 99);
            if (a < 18)      press(1, 0, $urandom_range(1, 6));
            else if (a < 42) press(0, 1, $urandom_range(1, 6));
            else if (a < 47) press(1, 1, $urandom_range(1, 6));
            else if (a < 62) sw_dir = ~sw_dir;
            else if (a < 65) pulse_reset(1'($urandom_range(0, 1)));
            idle($urandom_range(1, 30));
        end
        idle(5);

        total++;
        if (steps_seen == 0) begin
            bad++;
            $display("FAIL step_cov got=%0d exp=>0", steps_seen);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
